// File: rtl/line_clock.sv
// KW11-L compatible line clock: prescaled timer tick, debounced panel enable,
// Wishbone CSR and either a CPU event pulse or a vectored interrupt.
module line_clock #(
  parameter int unsigned CLKREF    = 50000000,
  parameter int unsigned FREQ      = 50,
  parameter int unsigned DEBOUNCE  = 2,
  parameter logic [15:0] CSR_ADDR  = 16'o177546,
  parameter logic [15:0] VECTOR    = 16'o000100,
  parameter bit          EVNT_MODE = 1'b0
) (
  input  logic        clk_p,
  input  logic        dclo,
  input  logic [15:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic        evnt_o,
  output logic        irq_o,
  input  logic        istb_i,
  output logic [15:0] ivec_o,
  output logic        iack_o,
  input  logic        timer_button,
  output logic        timer_status,
  output logic        tick_o
);

  localparam int unsigned LIMIT = CLKREF / FREQ;
  localparam int unsigned CW    = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  typedef enum logic {
    V_IDLE,
    V_ACK
  } vstate_t;

  logic                w_irqMode;
  logic [CW-1:0]       r_count;
  logic                r_tick;
  logic                w_countLast;

  logic [DEBOUNCE-1:0] r_deb;
  logic [DEBOUNCE-1:0] w_debNext;
  logic                w_allOnes;
  logic                w_allZeros;
  logic                r_rearm;
  logic                r_status;

  logic                w_hit;
  logic                w_wr;
  logic                r_ack;
  logic [15:0]         r_dat;
  logic [15:0]         w_csr;
  logic                r_mon;
  logic                r_ie;

  logic                r_pend;
  logic                w_pendSet;
  logic                w_ieClr;
  logic                w_vack;
  vstate_t             r_vstate;
  vstate_t             w_vstateNext;
  logic                w_iack;
  logic [15:0]         w_ivec;

  logic                w_unused;

  assign w_irqMode   = EVNT_MODE;
  assign w_countLast = (r_count == LAST);

  always_ff @(posedge clk_p) begin
    if (dclo) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick  <= w_countLast;
      r_count <= w_countLast ? '0 : r_count + CW'(1);
    end
  end

  // Next debounce window: the button enters at bit 0, oldest sample is the MSB.
  always_comb begin
    w_debNext    = r_deb;
    w_debNext[0] = timer_button;
    for (int i = 1; i < DEBOUNCE; i++) begin
      w_debNext[i] = r_deb[i-1];
    end
  end

  assign w_allOnes  = &w_debNext;
  assign w_allZeros = ~|w_debNext;

  always_ff @(posedge clk_p) begin
    if (dclo) begin
      r_deb    <= '0;
      r_rearm  <= 1'b0;
      r_status <= 1'b0;
    end else if (r_tick) begin
      r_deb <= w_debNext;
      if (w_allOnes && !r_rearm) begin
        r_status <= ~r_status;
        r_rearm  <= 1'b1;
      end else if (w_allZeros) begin
        r_rearm <= 1'b0;
      end
    end
  end

  assign w_hit = wb_stb_i & (wb_adr_i[15:1] == CSR_ADDR[15:1]);
  assign w_wr  = w_hit & wb_we_i & ~r_ack & wb_sel_i[0];
  assign w_csr = {8'h00, r_mon, r_ie, 6'b000000};

  always_ff @(posedge clk_p) begin
    if (dclo) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_hit;
      r_dat <= (w_hit & ~wb_we_i) ? w_csr : 16'h0000;
    end
  end

  // A tick always wins over a clearing write so a monitor event is never lost.
  always_ff @(posedge clk_p) begin
    if (dclo) begin
      r_mon <= 1'b0;
      r_ie  <= 1'b0;
    end else begin
      if (r_tick && r_status) begin
        r_mon <= 1'b1;
      end else if (w_wr && !wb_dat_i[7]) begin
        r_mon <= 1'b0;
      end
      if (w_wr) begin
        r_ie <= wb_dat_i[6];
      end
    end
  end

  assign w_pendSet = w_irqMode & r_tick & r_status & r_ie;
  assign w_ieClr   = w_wr & ~wb_dat_i[6];
  assign w_vack    = (r_vstate == V_IDLE) & istb_i & r_pend;

  // Disabling the interrupt cancels it; a fresh tick survives a vector grant.
  always_ff @(posedge clk_p) begin
    if (dclo) begin
      r_pend <= 1'b0;
    end else if (w_ieClr) begin
      r_pend <= 1'b0;
    end else if (w_pendSet) begin
      r_pend <= 1'b1;
    end else if (w_vack) begin
      r_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk_p) begin
    if (dclo) begin
      r_vstate <= V_IDLE;
    end else begin
      r_vstate <= w_vstateNext;
    end
  end

  always_comb begin
    w_vstateNext = r_vstate;
    w_iack       = 1'b0;
    w_ivec       = 16'h0000;
    case (r_vstate)
      V_IDLE: begin
        if (istb_i && r_pend) begin
          w_vstateNext = V_ACK;
        end
      end
      V_ACK: begin
        w_iack = 1'b1;
        w_ivec = VECTOR;
        if (!istb_i) begin
          w_vstateNext = V_IDLE;
        end
      end
      default: w_vstateNext = V_IDLE;
    endcase
  end

  assign wb_ack_o     = r_ack;
  assign wb_dat_o     = r_dat;
  assign tick_o       = r_tick;
  assign timer_status = r_status;
  assign evnt_o       = w_irqMode ? 1'b0 : (r_tick & r_status);
  assign irq_o        = r_pend;
  assign iack_o       = w_iack;
  assign ivec_o       = w_ivec;

  assign w_unused = ^{wb_dat_i[15:8], wb_dat_i[5:0], wb_sel_i[1], wb_adr_i[0]};

endmodule

// File: tb/tb_line_clock.sv
// Directed bench for line_clock: one pulse-mode and one IRQ-mode instance
// share stimulus; expected values are hand-computed against a 10-cycle tick.
module tb_line_clock;

  localparam logic [15:0] CSR  = 16'o177546;
  localparam logic [15:0] MISS = 16'o177544;

  logic        clk = 1'b0;
  logic        dclo;
  logic [15:0] wbAdr;
  logic [15:0] wbDatI;
  logic        wbWe;
  logic [1:0]  wbSel;
  logic        wbStb;
  logic        istb;
  logic        button;

  logic [15:0] dat0, dat1, ivec0, ivec1;
  logic        ack0, ack1, evnt0, evnt1, irq0, irq1, iack0, iack1;
  logic        status0, status1, tick0, tick1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  line_clock #(.CLKREF(1000), .FREQ(100), .DEBOUNCE(2), .CSR_ADDR(CSR),
               .VECTOR(16'o000100), .EVNT_MODE(1'b0)) u0 (
    .clk_p(clk), .dclo(dclo), .wb_adr_i(wbAdr), .wb_dat_i(wbDatI),
    .wb_dat_o(dat0), .wb_we_i(wbWe), .wb_sel_i(wbSel), .wb_stb_i(wbStb),
    .wb_ack_o(ack0), .evnt_o(evnt0), .irq_o(irq0), .istb_i(istb),
    .ivec_o(ivec0), .iack_o(iack0), .timer_button(button),
    .timer_status(status0), .tick_o(tick0)
  );

  line_clock #(.CLKREF(1000), .FREQ(100), .DEBOUNCE(2), .CSR_ADDR(CSR),
               .VECTOR(16'o000100), .EVNT_MODE(1'b1)) u1 (
    .clk_p(clk), .dclo(dclo), .wb_adr_i(wbAdr), .wb_dat_i(wbDatI),
    .wb_dat_o(dat1), .wb_we_i(wbWe), .wb_sel_i(wbSel), .wb_stb_i(wbStb),
    .wb_ack_o(ack1), .evnt_o(evnt1), .irq_o(irq1), .istb_i(istb),
    .ivec_o(ivec1), .iack_o(iack1), .timer_button(button),
    .timer_status(status1), .tick_o(tick1)
  );

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s at cyc %0d: observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic stb, input logic [15:0] adr, input logic we,
                               input logic [1:0] sel, input logic [15:0] dat);
    wbStb  = stb;
    wbAdr  = adr;
    wbWe   = we;
    wbSel  = sel;
    wbDatI = dat;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic runTo(input int target);
    while (cyc < target) step();
  endtask

  initial begin
    dclo   = 1'b1;
    istb   = 1'b0;
    button = 1'b0;
    applyStimulus(1'b0, 16'h0000, 1'b0, 2'b00, 16'h0000);
    repeat (3) step();

    checkOutput("rst_tick",   16'(tick0),   16'h0);
    checkOutput("rst_evnt",   16'(evnt0),   16'h0);
    checkOutput("rst_irq",    16'(irq1),    16'h0);
    checkOutput("rst_iack",   16'(iack1),   16'h0);
    checkOutput("rst_ivec",   ivec1,        16'h0);
    checkOutput("rst_ack",    16'(ack0),    16'h0);
    checkOutput("rst_dat",    dat0,         16'h0);
    checkOutput("rst_status", 16'(status0), 16'h0);

    // Release reset: ticks after edges 10, 20, 30.
    dclo = 1'b0;
    cyc  = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      checkOutput("tick0_period", 16'(tick0), ((cyc % 10) == 0) ? 16'h1 : 16'h0);
      checkOutput("tick1_period", 16'(tick1), ((cyc % 10) == 0) ? 16'h1 : 16'h0);
      checkOutput("evnt_off",     16'(evnt0), 16'h0);
    end

    runTo(32); applyStimulus(1'b1, CSR, 1'b0, 2'b11, 16'h0000);
    runTo(33);
    checkOutput("rd_idle_ack", 16'(ack0), 16'h1);
    checkOutput("rd_idle_dat", dat0, 16'h0000);
    applyStimulus(1'b0, CSR, 1'b0, 2'b00, 16'h0000);
    runTo(34);
    checkOutput("ack_fall", 16'(ack0), 16'h0);
    applyStimulus(1'b1, MISS, 1'b0, 2'b11, 16'h0000);
    runTo(35);
    checkOutput("miss_noack", 16'(ack0), 16'h0);
    applyStimulus(1'b0, CSR, 1'b0, 2'b00, 16'h0000);
    button = 1'b1;

    // Button high across ticks 40 and 50: toggle on the edge after tick 50.
    runTo(50); checkOutput("deb_before", 16'(status0), 16'h0);
    runTo(51); checkOutput("deb_on",     16'(status0), 16'h1);
    runTo(59); checkOutput("evnt_gap",   16'(evnt0),   16'h0);
    runTo(60);
    checkOutput("evnt_pulse", 16'(evnt0), 16'h1);
    checkOutput("evnt_mode1", 16'(evnt1), 16'h0);
    runTo(61);
    checkOutput("evnt_width", 16'(evnt0),   16'h0);
    checkOutput("deb_hold",   16'(status0), 16'h1);

    runTo(62); applyStimulus(1'b1, CSR, 1'b0, 2'b11, 16'h0000);
    runTo(63);
    checkOutput("mon_ack", 16'(ack0), 16'h1);
    checkOutput("mon_set", dat0, 16'o200);
    applyStimulus(1'b0, CSR, 1'b0, 2'b00, 16'h0000);

    runTo(64); applyStimulus(1'b1, CSR, 1'b1, 2'b10, 16'h0000);
    runTo(65);
    checkOutput("wr_hi_ack", 16'(ack0), 16'h1);
    checkOutput("wr_dat0",   dat0, 16'h0000);
    applyStimulus(1'b0, CSR, 1'b0, 2'b00, 16'h0000);
    runTo(66); applyStimulus(1'b1, CSR, 1'b0, 2'b11, 16'h0000);
    runTo(67); checkOutput("wr_hi_nochg", dat0, 16'o200);
    applyStimulus(1'b0, CSR, 1'b0, 2'b00, 16'h0000);

    runTo(68); applyStimulus(1'b1, CSR, 1'b1, 2'b01, 16'h0000);
    runTo(69); applyStimulus(1'b0, CSR, 1'b0, 2'b00, 16'h0000);
    runTo(70);
    checkOutput("evnt_70", 16'(evnt0), 16'h1);
    applyStimulus(1'b1, CSR, 1'b0, 2'b11, 16'h0000);
    runTo(71); checkOutput("mon_clr", dat0, 16'h0000);
    applyStimulus(1'b0, CSR, 1'b0, 2'b00, 16'h0000);

    // Clearing write lands on the same edge as the tick-80 update.
    runTo(80);
    checkOutput("tick_80", 16'(tick0), 16'h1);
    applyStimulus(1'b1, CSR, 1'b1, 2'b01, 16'h0000);
    runTo(81); applyStimulus(1'b0, CSR, 1'b0, 2'b00, 16'h0000);
    runTo(82); applyStimulus(1'b1, CSR, 1'b0, 2'b11, 16'h0000);
    runTo(83); checkOutput("mon_tick_wins", dat0, 16'o200);
    applyStimulus(1'b0, CSR, 1'b0, 2'b00, 16'h0000);

    runTo(84); applyStimulus(1'b1, CSR, 1'b1, 2'b01, 16'o100);
    runTo(85); applyStimulus(1'b0, CSR, 1'b0, 2'b00, 16'h0000);
    runTo(90);
    checkOutput("irq_before", 16'(irq1),  16'h0);
    checkOutput("evnt_90",    16'(evnt0), 16'h1);
    runTo(91);
    checkOutput("irq_set",   16'(irq1), 16'h1);
    checkOutput("irq_mode0", 16'(irq0), 16'h0);
    runTo(92); istb = 1'b1;
    runTo(93);
    checkOutput("iack_rise",  16'(iack1), 16'h1);
    checkOutput("ivec_val",   ivec1,      16'o100);
    checkOutput("irq_clr",    16'(irq1),  16'h0);
    checkOutput("iack_mode0", 16'(iack0), 16'h0);
    runTo(95);
    checkOutput("iack_hold", 16'(iack1), 16'h1);
    istb = 1'b0;
    runTo(96);
    checkOutput("iack_fall", 16'(iack1), 16'h0);
    checkOutput("ivec_zero", ivec1,      16'h0);
    runTo(97); istb = 1'b1;
    runTo(98); checkOutput("iack_nopend", 16'(iack1), 16'h0);
    istb = 1'b0;

    // Grant and tick share the edge after cycle 110: request survives.
    runTo(101); checkOutput("irq_101", 16'(irq1), 16'h1);
    runTo(110); istb = 1'b1;
    runTo(111);
    checkOutput("iack_tick",  16'(iack1), 16'h1);
    checkOutput("irq_tick",   16'(irq1),  16'h1);
    checkOutput("ivec_tick",  ivec1,      16'o100);
    istb = 1'b0;
    runTo(112);
    checkOutput("iack_112", 16'(iack1), 16'h0);
    checkOutput("irq_112",  16'(irq1),  16'h1);
    runTo(113); applyStimulus(1'b1, CSR, 1'b1, 2'b01, 16'h0000);
    runTo(114);
    checkOutput("irq_ieclr", 16'(irq1), 16'h0);
    applyStimulus(1'b0, CSR, 1'b0, 2'b00, 16'h0000);

    // Release for two ticks, press for two ticks: latch turns off.
    runTo(115); button = 1'b0;
    runTo(132); button = 1'b1;
    runTo(150); checkOutput("deb_off_before", 16'(status0), 16'h1);
    runTo(151); checkOutput("deb_off",        16'(status0), 16'h0);
    runTo(152); button = 1'b0;
    runTo(172); button = 1'b1;
    runTo(181); checkOutput("glitch_mid", 16'(status0), 16'h0);
    runTo(182); button = 1'b0;
    runTo(201); checkOutput("glitch_end", 16'(status0), 16'h0);

    runTo(202); applyStimulus(1'b1, CSR, 1'b1, 2'b01, 16'h0000);
    runTo(203); applyStimulus(1'b0, CSR, 1'b0, 2'b00, 16'h0000);
    runTo(210);
    checkOutput("tick_210", 16'(tick0), 16'h1);
    checkOutput("evnt_dis", 16'(evnt0), 16'h0);
    runTo(212); applyStimulus(1'b1, CSR, 1'b0, 2'b11, 16'h0000);
    runTo(213); checkOutput("mon_dis", dat0, 16'h0000);
    applyStimulus(1'b0, CSR, 1'b0, 2'b00, 16'h0000);
    button = 1'b1;

    runTo(231); checkOutput("deb_on2", 16'(status0), 16'h1);
    runTo(232); applyStimulus(1'b1, CSR, 1'b1, 2'b01, 16'o100);
    runTo(233); applyStimulus(1'b0, CSR, 1'b0, 2'b00, 16'h0000);
    runTo(241); checkOutput("irq_241", 16'(irq1), 16'h1);
    runTo(242); applyStimulus(1'b1, CSR, 1'b0, 2'b11, 16'h0000);
    runTo(243);
    checkOutput("rd_full_ack", 16'(ack0), 16'h1);
    checkOutput("rd_full0",    dat0, 16'o300);
    checkOutput("rd_full1",    dat1, 16'o300);
    dclo = 1'b1;

    // Reset lands mid-read: everything back to idle on the next edge.
    runTo(244);
    checkOutput("dclo_ack",    16'(ack0),    16'h0);
    checkOutput("dclo_dat",    dat0,         16'h0000);
    checkOutput("dclo_status", 16'(status0), 16'h0);
    checkOutput("dclo_irq",    16'(irq1),    16'h0);
    checkOutput("dclo_tick",   16'(tick0),   16'h0);
    checkOutput("dclo_evnt",   16'(evnt0),   16'h0);
    checkOutput("dclo_iack",   16'(iack1),   16'h0);
    checkOutput("dclo_ivec",   ivec1,        16'h0000);
    dclo   = 1'b0;
    button = 1'b0;
    applyStimulus(1'b0, CSR, 1'b0, 2'b00, 16'h0000);
    runTo(253); checkOutput("restart_pre",  16'(tick0), 16'h0);
    runTo(254); checkOutput("restart_tick", 16'(tick0), 16'h1);
    runTo(255); applyStimulus(1'b1, CSR, 1'b0, 2'b11, 16'h0000);
    runTo(256);
    checkOutput("restart_ack", 16'(ack0), 16'h1);
    checkOutput("restart_csr", dat0, 16'h0000);
    applyStimulus(1'b0, CSR, 1'b0, 2'b00, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
